// File: rtl/pll_phase_shift_arbiter.sv
// rtl/pll_phase_shift_arbiter.sv - round-robin arbiter sharing one PLL fine-phase-shift port
// Issues one step at a time, tracks signed position, enforces range limit and done-timeout.
module pll_phase_shift_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int STEP_WIDTH = 8,
  parameter int POS_WIDTH  = 16,
  parameter int POS_LIMIT  = 1120,
  parameter int TIMEOUT    = 255,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk_312p5mhz,
  input  logic                          rst_n,
  input  logic                          pll_lock,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_inc,
  input  logic [NUM_REQ*STEP_WIDTH-1:0] req_steps,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            cmd_done,
  output logic [NUM_REQ-1:0]            cmd_error,
  output logic                          phase_shift_en,
  output logic                          phase_shift_inc,
  input  logic                          phase_shift_done,
  output logic [POS_WIDTH-1:0]          position,
  output logic                          busy,
  output logic                          timeout_fault
);
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic signed [POS_WIDTH:0] LIM_HI = (POS_WIDTH+1)'(POS_LIMIT);
  localparam logic signed [POS_WIDTH:0] LIM_LO = -LIM_HI;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_GAP, S_COMPLETE
  } state_t;

  state_t                   r_state, w_next;
  logic [IDX_W-1:0]         r_gnt, r_last, w_gidx, w_cand;
  logic                     w_found, w_grant;
  logic                     r_inc;
  logic [STEP_WIDTH-1:0]    r_steps;
  logic                     r_err, w_err_next;
  logic [TMO_W-1:0]         r_tmo;
  logic [GAP_W-1:0]         r_gap;
  logic signed [POS_WIDTH-1:0] r_pos;
  logic                     r_fault;
  logic signed [POS_WIDTH:0] w_pos_ext, w_steps_ext, w_target;
  logic                     w_out_of_range, w_tmo_hit, w_gap_end;

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found && pll_lock && !r_fault;

  assign w_pos_ext   = {r_pos[POS_WIDTH-1], r_pos};
  assign w_steps_ext = {{(POS_WIDTH+1-STEP_WIDTH){1'b0}}, r_steps};
  assign w_target    = r_inc ? (w_pos_ext + w_steps_ext) : (w_pos_ext - w_steps_ext);
  assign w_out_of_range = (w_target > LIM_HI) || (w_target < LIM_LO);
  assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_gap_end   = (r_gap == GAP_W'(GAP_LAST));

  always_comb begin
    w_next     = r_state;
    w_err_next = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next     = S_CHECK;
          w_err_next = 1'b0;
        end
      end
      S_CHECK: begin
        if (r_steps == '0) begin
          w_next = S_COMPLETE;
        end else if (w_out_of_range) begin
          w_next     = S_COMPLETE;
          w_err_next = 1'b1;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pll_lock) begin
          w_next = S_WAIT;
        end else begin
          w_next     = S_COMPLETE;
          w_err_next = 1'b1;
        end
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still counts as a completed step.
        if (phase_shift_done) begin
          if (r_steps == '0) begin
            w_next = S_COMPLETE;
          end else if (!pll_lock) begin
            w_next     = S_COMPLETE;
            w_err_next = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            w_next = S_ISSUE;
          end else begin
            w_next = S_GAP;
          end
        end else if (w_tmo_hit) begin
          w_next     = S_COMPLETE;
          w_err_next = 1'b1;
        end
      end
      S_GAP: begin
        if (!pll_lock) begin
          w_next     = S_COMPLETE;
          w_err_next = 1'b1;
        end else if (w_gap_end) begin
          w_next = S_ISSUE;
        end
      end
      S_COMPLETE: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_gnt   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_inc   <= 1'b0;
      r_steps <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_pos   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if (w_grant) begin
        r_gnt   <= w_gidx;
        r_inc   <= req_inc[w_gidx];
        r_steps <= req_steps[w_gidx*STEP_WIDTH +: STEP_WIDTH];
      end
      if (r_state == S_ISSUE && pll_lock) begin
        r_steps <= r_steps - 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (r_state == S_GAP) begin
        r_gap <= r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end
      if (r_state == S_WAIT && phase_shift_done) begin
        r_pos <= r_inc ? (r_pos + POS_WIDTH'(1)) : (r_pos - POS_WIDTH'(1));
      end
      if (r_state == S_WAIT && !phase_shift_done && w_tmo_hit) begin
        r_fault <= 1'b1;
      end
      if (r_state == S_COMPLETE) begin
        r_last <= r_gnt;
      end
    end
  end

  assign req_ready       = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
  assign cmd_done        = (r_state == S_COMPLETE) ? (NUM_REQ'(1) << r_gnt) : '0;
  assign cmd_error       = (r_state == S_COMPLETE && r_err) ? (NUM_REQ'(1) << r_gnt) : '0;
  assign phase_shift_en  = (r_state == S_ISSUE) && pll_lock;
  assign phase_shift_inc = phase_shift_en & r_inc;
  assign position        = r_pos;
  assign busy            = (r_state != S_IDLE);
  assign timeout_fault   = r_fault;

endmodule

// File: tb/tb_pll_phase_shift_arbiter.sv
// tb/tb_pll_phase_shift_arbiter.sv - randomized self-checking bench for pll_phase_shift_arbiter
// Reference model predicts each command's outcome from position, direction and step count.
module tb_pll_phase_shift_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int STEP_WIDTH = 8;
  localparam int POS_WIDTH  = 16;
  localparam int POS_LIMIT  = 1120;
  localparam int TIMEOUT    = 255;
  localparam int GAP_CYCLES = 2;

  logic clk_312p5mhz = 1'b0;
  always #5 clk_312p5mhz = ~clk_312p5mhz;

  logic                          rst_n = 1'b0;
  logic                          pll_lock = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ-1:0]            req_inc = '0;
  logic [NUM_REQ*STEP_WIDTH-1:0] req_steps = '0;
  logic [NUM_REQ-1:0]            req_ready, cmd_done, cmd_error;
  logic                          phase_shift_en, phase_shift_inc;
  logic                          phase_shift_done = 1'b0;
  logic [POS_WIDTH-1:0]          position;
  logic                          busy, timeout_fault;

  pll_phase_shift_arbiter #(
    .NUM_REQ(NUM_REQ), .STEP_WIDTH(STEP_WIDTH), .POS_WIDTH(POS_WIDTH),
    .POS_LIMIT(POS_LIMIT), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk_312p5mhz(clk_312p5mhz), .rst_n(rst_n), .pll_lock(pll_lock),
    .req_valid(req_valid), .req_inc(req_inc), .req_steps(req_steps),
    .req_ready(req_ready), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .phase_shift_en(phase_shift_en), .phase_shift_inc(phase_shift_inc),
    .phase_shift_done(phase_shift_done), .position(position),
    .busy(busy), .timeout_fault(timeout_fault)
  );

  int checks = 0, failures = 0, cyc = 0;
  bit pll_respond = 1'b1, stray = 1'b0, pending = 1'b0, cur_inc = 1'b0;
  int dly_min = 1, dly_max = 1, due = 0;
  int en_count = 0, done_count = 0, last_en_cyc = -1000, min_en_gap = 1000000;
  int overlap_errs = 0, inc_errs = 0;
  logic [NUM_REQ-1:0] s_ready, s_done, s_err;
  int exp_pos = 0, exp_last = NUM_REQ - 1;

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void predict(input int pos, input bit inc, input int steps,
                                  output bit rej, output int npulse, output int npos);
    int tgt;
    tgt    = inc ? pos + steps : pos - steps;
    rej    = (steps != 0) && ((tgt > POS_LIMIT) || (tgt < -POS_LIMIT));
    npulse = rej ? 0 : steps;
    npos   = rej ? pos : tgt;
  endfunction

  // One clock: sample at negedge, run the PLL responder, return just after posedge.
  task automatic tick();
    @(negedge clk_312p5mhz);
    s_ready = req_ready;
    s_done  = cmd_done;
    s_err   = cmd_error;
    if (phase_shift_en) begin
      if (pending) overlap_errs++;
      if (phase_shift_inc !== cur_inc) inc_errs++;
      if (cyc - last_en_cyc < min_en_gap) min_en_gap = cyc - last_en_cyc;
      last_en_cyc = cyc;
      en_count++;
      pending = 1'b1;
      due = cyc + int'($urandom_range(dly_max, dly_min));
    end
    if (|s_done) pending = 1'b0;
    phase_shift_done = 1'b0;
    if (pending && pll_respond && cyc == due) begin
      phase_shift_done = 1'b1;
      pending = 1'b0;
      done_count++;
    end
    if (stray) phase_shift_done = 1'b1;
    @(posedge clk_312p5mhz);
    #1;
    cyc++;
  endtask

  task automatic run_cmd(input int r, input bit inc, input int steps,
                         output bit got_done, output logic [NUM_REQ-1:0] dvec,
                         output logic [NUM_REQ-1:0] evec, output int pulses,
                         output int rdy_cyc, output int done_cyc);
    bit got_ready;
    int e0;
    got_ready = 1'b0; got_done = 1'b0; dvec = '0; evec = '0;
    rdy_cyc = -1; done_cyc = -1;
    cur_inc = inc;
    req_inc[r] = inc;
    req_steps[r*STEP_WIDTH +: STEP_WIDTH] = STEP_WIDTH'(steps);
    req_valid[r] = 1'b1;
    for (int b = 0; b < 64 && !got_ready; b++) begin
      tick();
      if (s_ready[r]) begin
        got_ready = 1'b1;
        rdy_cyc = cyc - 1;
      end
    end
    req_valid[r] = 1'b0;
    if (got_ready) exp_last = r;
    e0 = en_count;
    for (int b = 0; b < 6000 && got_ready && !got_done; b++) begin
      tick();
      if (|s_done) begin
        got_done = 1'b1;
        dvec = s_done;
        evec = s_err;
        done_cyc = cyc - 1;
      end
    end
    pulses = en_count - e0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_lock = 1'b1;
    repeat (3) @(posedge clk_312p5mhz);
    @(negedge clk_312p5mhz);
    checks++;
    if ({req_ready, cmd_done, cmd_error, phase_shift_en, phase_shift_inc, busy, timeout_fault} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0",
               {req_ready, cmd_done, cmd_error, phase_shift_en, phase_shift_inc, busy, timeout_fault});
    end
    checks++;
    if (position !== '0) begin
      failures++;
      $display("FAIL reset_position: got %0d expected 0", position);
    end
    @(posedge clk_312p5mhz);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit gd; logic [NUM_REQ-1:0] dv, ev; int p, rc, dc;
    dly_min = 12; dly_max = 12; min_en_gap = 1000000;
    run_cmd(0, 1'b1, 3, gd, dv, ev, p, rc, dc);
    exp_pos += 3;
    checks++;
    if (!gd || dv !== oh(0) || ev !== '0) begin
      failures++;
      $display("FAIL single_done: got done=%0d vec=%b err=%b expected vec=01 err=00", gd, dv, ev);
    end
    checks++;
    if (p !== 3) begin failures++; $display("FAIL single_pulses: got %0d expected 3", p); end
    checks++;
    if (min_en_gap < GAP_CYCLES + 1) begin
      failures++;
      $display("FAIL single_spacing: got %0d expected >= %0d", min_en_gap, GAP_CYCLES + 1);
    end
    checks++;
    if (int'($signed(position)) !== exp_pos) begin
      failures++;
      $display("FAIL single_position: got %0d expected %0d", $signed(position), exp_pos);
    end
    dly_min = 5; dly_max = 5;
    run_cmd(0, 1'b0, 1, gd, dv, ev, p, rc, dc);
    exp_pos -= 1;
    checks++;
    if (!gd || last_en_cyc - rc !== 2 || dc - rc !== 8) begin
      failures++;
      $display("FAIL latency: got en=+%0d done=+%0d expected en=+2 done=+8", last_en_cyc - rc, dc - rc);
    end
    checks++;
    if (int'($signed(position)) !== exp_pos || inc_errs !== 0) begin
      failures++;
      $display("FAIL latency_position: got %0d inc_errs=%0d expected %0d inc_errs=0",
               $signed(position), inc_errs, exp_pos);
    end
  endtask

  task automatic test_round_robin();
    int readies, dones, expg;
    readies = 0; dones = 0;
    dly_min = 1; dly_max = 4; cur_inc = 1'b1;
    req_inc = '1;
    for (int i = 0; i < NUM_REQ; i++) req_steps[i*STEP_WIDTH +: STEP_WIDTH] = STEP_WIDTH'(1);
    req_valid = '1;
    for (int b = 0; b < 400 && dones < 4; b++) begin
      tick();
      if (|s_ready) begin
        expg = (exp_last + 1) % NUM_REQ;
        checks++;
        if (s_ready !== oh(expg)) begin
          failures++;
          $display("FAIL rr_grant: got %b expected %b", s_ready, oh(expg));
        end
        exp_last = expg;
        readies++;
      end
      if (|s_done) begin
        dones++;
        exp_pos++;
        if (dones == 4) req_valid = '0;
      end
    end
    req_valid = '0;
    checks++;
    if (dones !== 4 || readies !== 4) begin
      failures++;
      $display("FAIL rr_counts: got dones=%0d readies=%0d expected 4 and 4", dones, readies);
    end
    checks++;
    if (int'($signed(position)) !== exp_pos) begin
      failures++;
      $display("FAIL rr_position: got %0d expected %0d", $signed(position), exp_pos);
    end
  endtask

  task automatic test_limit();
    bit gd; logic [NUM_REQ-1:0] dv, ev; int p, rc, dc, diff, st;
    dly_min = 1; dly_max = 2;
    for (int i = 0; i < 20 && exp_pos != 1118; i++) begin
      diff = 1118 - exp_pos;
      st = (diff > 0) ? diff : -diff;
      if (st > 255) st = 255;
      run_cmd(0, diff > 0, st, gd, dv, ev, p, rc, dc);
      exp_pos += (diff > 0) ? st : -st;
    end
    checks++;
    if (int'($signed(position)) !== 1118) begin
      failures++;
      $display("FAIL limit_walk: got %0d expected 1118", $signed(position));
    end
    run_cmd(1, 1'b1, 5, gd, dv, ev, p, rc, dc);
    checks++;
    if (!gd || dv !== oh(1) || ev !== oh(1) || p !== 0) begin
      failures++;
      $display("FAIL limit_reject: got vec=%b err=%b pulses=%0d expected 10 10 0", dv, ev, p);
    end
    checks++;
    if (int'($signed(position)) !== 1118) begin
      failures++;
      $display("FAIL limit_reject_position: got %0d expected 1118", $signed(position));
    end
    run_cmd(1, 1'b1, 2, gd, dv, ev, p, rc, dc);
    exp_pos = 1120;
    checks++;
    if (!gd || ev !== '0 || p !== 2 || int'($signed(position)) !== 1120) begin
      failures++;
      $display("FAIL limit_edge: got err=%b pulses=%0d pos=%0d expected 00 2 1120", ev, p, $signed(position));
    end
  endtask

  task automatic test_random();
    bit gd, inc, rej; logic [NUM_REQ-1:0] dv, ev; int p, rc, dc, r, st, np, npos;
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(NUM_REQ - 1, 0));
      inc = bit'($urandom_range(1, 0));
      st = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(60, 1));
      dly_min = 1; dly_max = int'($urandom_range(8, 1));
      predict(exp_pos, inc, st, rej, np, npos);
      run_cmd(r, inc, st, gd, dv, ev, p, rc, dc);
      checks++;
      if (!gd || dv !== oh(r) || ev !== (rej ? oh(r) : '0) || p !== np) begin
        failures++;
        $display("FAIL random_cmd%0d: got vec=%b err=%b pulses=%0d expected vec=%b err=%0d pulses=%0d",
                 i, dv, ev, p, oh(r), rej, np);
      end
      exp_pos = npos;
      checks++;
      if (int'($signed(position)) !== exp_pos) begin
        failures++;
        $display("FAIL random_pos%0d: got %0d expected %0d", i, $signed(position), exp_pos);
      end
    end
    checks++;
    if (overlap_errs !== 0 || inc_errs !== 0) begin
      failures++;
      $display("FAIL step_protocol: got overlap=%0d inc_errs=%0d expected 0 0", overlap_errs, inc_errs);
    end
  endtask

  task automatic test_zero_and_stray();
    bit gd; logic [NUM_REQ-1:0] dv, ev; int p, rc, dc;
    run_cmd(0, 1'b1, 0, gd, dv, ev, p, rc, dc);
    checks++;
    if (!gd || dv !== oh(0) || ev !== '0 || p !== 0) begin
      failures++;
      $display("FAIL zero_steps: got vec=%b err=%b pulses=%0d expected 01 00 0", dv, ev, p);
    end
    stray = 1'b1;
    repeat (3) tick();
    stray = 1'b0;
    tick();
    checks++;
    if (int'($signed(position)) !== exp_pos || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_done: got pos=%0d busy=%b expected %0d 0", $signed(position), busy, exp_pos);
    end
  endtask

  task automatic test_lock_drop();
    bit gd, got, inc; logic [NUM_REQ-1:0] dv, ev; int e0, d0, seen;
    gd = 1'b0; got = 1'b0; dv = '0; ev = '0; seen = 0;
    inc = (exp_pos < 0);
    dly_min = 3; dly_max = 6; cur_inc = inc;
    req_inc[0] = inc;
    req_steps[0 +: STEP_WIDTH] = STEP_WIDTH'(4);
    req_valid[0] = 1'b1;
    for (int b = 0; b < 64 && !got; b++) begin tick(); got = s_ready[0]; end
    req_valid[0] = 1'b0;
    e0 = en_count; d0 = done_count;
    for (int b = 0; b < 400 && done_count - d0 < 2; b++) tick();
    pll_lock = 1'b0;
    for (int b = 0; b < 400 && !gd; b++) begin
      tick();
      if (|s_done) begin gd = 1'b1; dv = s_done; ev = s_err; end
    end
    exp_pos += inc ? 2 : -2;
    checks++;
    if (!gd || dv !== oh(0) || ev !== oh(0) || en_count - e0 !== 2) begin
      failures++;
      $display("FAIL lock_abort: got vec=%b err=%b pulses=%0d expected 01 01 2", dv, ev, en_count - e0);
    end
    checks++;
    if (int'($signed(position)) !== exp_pos) begin
      failures++;
      $display("FAIL lock_position: got %0d expected %0d", $signed(position), exp_pos);
    end
    req_steps[STEP_WIDTH +: STEP_WIDTH] = '0;
    req_valid[1] = 1'b1;
    for (int b = 0; b < 20; b++) begin tick(); if (|s_ready) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL lock_low_grant: got %0d grants expected 0", seen); end
    pll_lock = 1'b1;
    got = 1'b0;
    for (int b = 0; b < 20 && !got; b++) begin tick(); got = s_ready[1]; end
    req_valid[1] = 1'b0;
    exp_last = 1;
    for (int b = 0; b < 10; b++) tick();
    checks++;
    if (!got || busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_regrant: got grant=%0d busy=%b expected 1 0", got, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 1'b0;
    dly_min = 3; dly_max = 3; cur_inc = 1'b1;
    req_inc[0] = 1'b1;
    req_steps[0 +: STEP_WIDTH] = STEP_WIDTH'(10);
    req_valid[0] = 1'b1;
    for (int b = 0; b < 64 && !got; b++) begin tick(); got = s_ready[0]; end
    req_valid[0] = 1'b0;
    for (int b = 0; b < 200 && en_count < 3 + b * 0 + (en_count - en_count); b++) tick();
    repeat (12) tick();
    #2;
    rst_n = 1'b0;
    phase_shift_done = 1'b0;
    pending = 1'b0;
    #1;
    checks++;
    if (position !== '0 || busy !== 1'b0 || phase_shift_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got pos=%0d busy=%b en=%b expected 0 0 0", position, busy, phase_shift_en);
    end
    @(posedge clk_312p5mhz);
    #1;
    rst_n = 1'b1;
    exp_pos = 0;
    exp_last = NUM_REQ - 1;
  endtask

  task automatic test_timeout();
    bit gd, inc; logic [NUM_REQ-1:0] dv, ev; int p, rc, dc, seen, span;
    seen = 0;
    inc = (exp_pos <= 0);
    pll_respond = 1'b0;
    run_cmd(0, inc, 3, gd, dv, ev, p, rc, dc);
    span = dc - last_en_cyc;
    checks++;
    if (!gd || ev !== oh(0) || p !== 1 || span < TIMEOUT || span > TIMEOUT + 2) begin
      failures++;
      $display("FAIL timeout_cmd: got err=%b pulses=%0d span=%0d expected 01 1 %0d..%0d",
               ev, p, span, TIMEOUT, TIMEOUT + 2);
    end
    checks++;
    if (timeout_fault !== 1'b1 || int'($signed(position)) !== exp_pos) begin
      failures++;
      $display("FAIL timeout_fault: got fault=%b pos=%0d expected 1 %0d", timeout_fault, $signed(position), exp_pos);
    end
    req_steps[STEP_WIDTH +: STEP_WIDTH] = '0;
    req_valid[1] = 1'b1;
    for (int b = 0; b < 40; b++) begin tick(); if (|s_ready) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL fault_blocks_grant: got %0d grants expected 0", seen); end
    rst_n = 1'b0;
    #2;
    checks++;
    if (timeout_fault !== 1'b0 || position !== '0) begin
      failures++;
      $display("FAIL fault_cleared: got fault=%b pos=%0d expected 0 0", timeout_fault, position);
    end
    @(posedge clk_312p5mhz);
    #1;
    rst_n = 1'b1;
    exp_pos = 0;
    pll_respond = 1'b1;
    pending = 1'b0;
    for (int b = 0; b < 20 && seen == 0; b++) begin tick(); if (s_ready[1]) seen++; end
    req_valid[1] = 1'b0;
    checks++;
    if (seen !== 1) begin failures++; $display("FAIL regrant_after_reset: got %0d grants expected 1", seen); end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_limit();
    test_random();
    test_zero_and_stray();
    test_lock_drop();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_phase_shift_arbiter.md
Name: pll_phase_shift_arbiter

Overview:
- Shares the single PLL fine-phase-shift port (en/inc/done, in the phase_shift_clk domain) between NUM_REQ requesters, e.g. the logic-pod phase alignment engine and a management/debug register interface.
- Accepts multi-step shift commands and arbitrates round-robin.
- Issues one PLL step at a time, handshaking on done.
- Tracks the signed cumulative phase offset, enforces a range limit, and detects lost-lock and done-timeout faults.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- STEP_WIDTH, 8, width of per-command step count.
- POS_WIDTH, 16, width of signed cumulative position.
- POS_LIMIT, 1120, maximum allowed |position| in fine-shift steps.
- TIMEOUT, 255, cycles to wait for phase_shift_done before declaring fault.
- GAP_CYCLES, 2, idle cycles between successive step pulses.

Ports:
- clk_312p5mhz  in  1  clock; same clock as the PLL phase_shift_clk.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock status, synchronous to clk.
- req_valid  in  NUM_REQ  command request per requester; held until accepted.
- req_inc  in  NUM_REQ  direction per requester (1 = increment); stable while valid.
- req_steps  in  NUM_REQ*STEP_WIDTH  step count per requester; slice i is [i*STEP_WIDTH +: STEP_WIDTH].
- req_ready  out  NUM_REQ  1-cycle accept strobe.
- cmd_done  out  NUM_REQ  1-cycle completion strobe.
- cmd_error  out  NUM_REQ  1-cycle strobe, coincident with cmd_done, on rejected or aborted command.
- phase_shift_en  out  1  1-cycle step pulse to PLL.
- phase_shift_inc  out  1  step direction to PLL; valid with en.
- phase_shift_done  in  1  PLL step-complete pulse.
- position  out  POS_WIDTH  signed cumulative completed steps since reset.
- busy  out  1  high in any state other than IDLE.
- timeout_fault  out  1  sticky; set on done timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, position 0, RR pointer selects requester 0 first, state IDLE.
- States: IDLE, CHECK, ISSUE, WAIT, GAP, COMPLETE.
- IDLE:
  - Grants only if pll_lock=1 and timeout_fault=0.
  - Picks the first valid requester after the last-granted index, wrapping.
  - Asserts req_ready[g] for one cycle and latches inc, steps and g; goes to CHECK.
- CHECK:
  - If steps==0: cmd_done[g] next cycle, no error, no PLL pulse.
  - Else computes target = position ± steps in POS_WIDTH+1 bits.
  - If |target| > POS_LIMIT: reject wholesale with cmd_done+cmd_error, no pulses, position unchanged.
  - Otherwise goes to ISSUE.
- ISSUE: phase_shift_en=1 for exactly one cycle with inc; remaining count decremented; goes to WAIT with timeout counter cleared.
- WAIT:
  - On phase_shift_done: position += ±1 in that cycle. If the remaining count is 0, go to COMPLETE; else go to GAP.
  - If the counter reaches TIMEOUT with no done: set timeout_fault, position unchanged for that step, cmd_done+cmd_error, then IDLE.
  - done and timeout in the same cycle: done wins.
- GAP: waits GAP_CYCLES, then goes to ISSUE. GAP_CYCLES=0 means going directly to ISSUE.
- COMPLETE: cmd_done[g] strobe for one cycle, then IDLE. The RR pointer updates to g.
- pll_lock falls in ISSUE/GAP/WAIT:
  - Abort after any outstanding WAIT resolves (done or timeout).
  - Issue cmd_done+cmd_error; position reflects completed steps only.
- phase_shift_done outside WAIT is ignored; it does not affect position.
- Latency, single 1-step command from IDLE: ready at T, en at T+2, done at T+2+d, cmd_done at T+3+d.
- At most one PLL step is outstanding at any time. en is never asserted twice without an intervening done or timeout.
- Asynchronous reset mid-command: all state cleared and position returns to 0. Software must re-align after reset, because the PLL phase is not reset.

Test Plan:
- Req0 steps=3 inc=1, PLL model returns done 12 cycles after each en -> exactly 3 en pulses ≥ GAP_CYCLES+1 apart, position 0→3, single cmd_done[0], no error.
- Req0 and req1 both valid continuously with steps=1 each -> grants alternate 0,1,0,1, with one req_ready per command.
- Position 1118, req steps=5 inc=1 -> cmd_done+cmd_error, zero en pulses, position stays 1118. Then steps=2 -> position 1120, success.
- PLL model never returns done -> after TIMEOUT=255 cycles: cmd_error, timeout_fault=1, position unchanged. A subsequent req_valid is never granted until rst_n pulses low.
- steps=4, pll_lock drops after the 2nd done -> no further en, cmd_error strobe, position=2. While lock is low, requests are not granted.
- steps=0 -> cmd_done without en. Separately, a stray phase_shift_done pulse while IDLE -> position unchanged.
